// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: sequences DDS frequency/amplitude words through soft start, stepped sweep and soft stop.
// Optional macro DDS_SWEEP_PINGPONG_EN: continuous mode alternates sweep direction instead of restarting.
module dds_sweep_ctrl #(
    parameter int FREQ_WIDTH  = 28,
    parameter int DAC_WIDTH   = 12,
    parameter int DWELL_WIDTH = 16,
    parameter int AMPL_STEP   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [FREQ_WIDTH-1:0]  cfg_f_start,
    input  logic [FREQ_WIDTH-1:0]  cfg_f_stop,
    input  logic [FREQ_WIDTH-1:0]  cfg_f_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [DAC_WIDTH-1:0]   cfg_ampl,
    input  logic                   cfg_continuous,
    input  logic                   abort,
    output logic [FREQ_WIDTH-1:0]  freq_kw,
    output logic [DAC_WIDTH-1:0]   ampl_kw,
    output logic                   busy,
    output logic                   step_strobe,
    output logic                   sweep_done
);
    typedef enum logic [1:0] {IDLE, RAMP_UP, DWELL, RAMP_DOWN} state_t;
    localparam logic [DAC_WIDTH:0] ASTEP = (DAC_WIDTH+1)'(AMPL_STEP);
    state_t                 state, state_nx;
    logic [FREQ_WIDTH-1:0]  f_start, f_stop, f_step, f_start_nx, f_stop_nx, freq_nx;
    logic [DWELL_WIDTH-1:0] dwell, cnt, cnt_nx, reload;
    logic [DAC_WIDTH-1:0]   a_tgt, ampl_nx, a_up, a_dn;
    logic [DAC_WIDTH:0]     a_sum;
    logic                   cont, up, up_nx, strobe_nx, done_nx, accept;
    // One sweep step toward t, clamping at t on overshoot, carry or zero step
    function automatic logic [FREQ_WIDTH-1:0] step_toward(
        input logic [FREQ_WIDTH-1:0] f, t, s, input logic u);
        logic [FREQ_WIDTH:0] sum;
        sum = {1'b0, f} + {1'b0, s};
        if (s == '0) return t;
        if (u) return (sum[FREQ_WIDTH] || sum[FREQ_WIDTH-1:0] >= t) ? t : sum[FREQ_WIDTH-1:0];
        return (s > f || f - s <= t) ? t : f - s;
    endfunction
    assign reload = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
    assign a_sum  = {1'b0, ampl_kw} + ASTEP;
    assign a_up   = (a_sum >= {1'b0, a_tgt}) ? a_tgt : a_sum[DAC_WIDTH-1:0];
    assign a_dn   = ({1'b0, ampl_kw} < ASTEP) ? '0 : ampl_kw - ASTEP[DAC_WIDTH-1:0];
    // Next-state and next-output decisions for the sweep sequencer
    always_comb begin
        state_nx   = state;
        freq_nx    = freq_kw;
        ampl_nx    = ampl_kw;
        cnt_nx     = cnt;
        f_start_nx = f_start;
        f_stop_nx  = f_stop;
        up_nx      = up;
        strobe_nx  = 1'b0;
        done_nx    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: if (cfg_valid) begin
                accept     = 1'b1;
                freq_nx    = cfg_f_start;
                f_start_nx = cfg_f_start;
                f_stop_nx  = cfg_f_stop;
                up_nx      = cfg_f_stop >= cfg_f_start;
                state_nx   = RAMP_UP;
            end
            RAMP_UP: begin
                if (abort) state_nx = RAMP_DOWN;
                else if (ampl_kw == a_tgt) begin
                    state_nx = DWELL;
                    cnt_nx   = reload;
                end else ampl_nx = a_up;
            end
            DWELL: begin
                if (abort) state_nx = RAMP_DOWN;
                else if (cnt > DWELL_WIDTH'(1)) cnt_nx = cnt - DWELL_WIDTH'(1);
                else begin
                    cnt_nx = reload;
                    if (freq_kw != f_stop) begin
                        freq_nx   = step_toward(freq_kw, f_stop, f_step, up);
                        strobe_nx = 1'b1;
                    end else if (!cont) state_nx = RAMP_DOWN;
                    else begin
`ifdef DDS_SWEEP_PINGPONG_EN
                        f_start_nx = f_stop;
                        f_stop_nx  = f_start;
                        up_nx      = ~up;
                        freq_nx    = step_toward(freq_kw, f_start, f_step, ~up);
`else
                        freq_nx    = f_start;
`endif
                        strobe_nx  = 1'b1;
                    end
                end
            end
            RAMP_DOWN: begin
                if (ampl_kw == '0) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else ampl_nx = a_dn;
            end
        endcase
    end
    // State, output and descriptor registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            freq_kw     <= '0;
            ampl_kw     <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            cfg_ready   <= 1'b1;
            step_strobe <= 1'b0;
            sweep_done  <= 1'b0;
            f_start     <= '0;
            f_stop      <= '0;
            f_step      <= '0;
            dwell       <= '0;
            a_tgt       <= '0;
            cont        <= 1'b0;
            up          <= 1'b1;
        end else begin
            state       <= state_nx;
            freq_kw     <= freq_nx;
            ampl_kw     <= ampl_nx;
            cnt         <= cnt_nx;
            busy        <= state_nx != IDLE;
            cfg_ready   <= state_nx == IDLE;
            step_strobe <= strobe_nx;
            sweep_done  <= done_nx;
            f_start     <= f_start_nx;
            f_stop      <= f_stop_nx;
            up          <= up_nx;
            if (accept) begin
                f_step <= cfg_f_step;
                dwell  <= cfg_dwell;
                a_tgt  <= cfg_ampl;
                cont   <= cfg_continuous;
            end
        end
    end
endmodule
